rr_grant_index: RTL and testbench

//   Round-robin arbiter that selects one of 2**WIDTH requesters and holds a registered binary

---
 rtl/rr_grant_index.sv | 101 ++++++++++
 tb/tb_rr_grant_index.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/rr_grant_index.sv
// rtl/rr_grant_index.sv - round-robin arbiter holding a registered binary grant index
// The holder is released by Done, Flush or an optional MAXHOLD timeout.
module rr_grant_index #(
  parameter int WIDTH   = 2,
  parameter int MAXHOLD = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2**WIDTH-1:0]   Req,
  input  logic                  Done,
  input  logic                  Flush,
  output logic                  GrantValid,
  output logic [WIDTH-1:0]      GrantIdx,
  output logic                  HoldTimeout
);
  localparam int N  = 2**WIDTH;
  localparam int CW = (MAXHOLD > 0) ? $clog2(MAXHOLD + 1) : 1;

  typedef enum logic {IDLE, GRANTED} state_t;

  state_t           state;
  logic [WIDTH-1:0] last_idx;
  logic [WIDTH-1:0] winner;
  logic [WIDTH-1:0] cand;
  logic             any;
  logic             hold_expire;

  // Search starts just past the last winner, so last_idx itself is lowest priority.
  always_comb begin
    winner = '0;
    cand   = '0;
    any    = 1'b0;
    for (int i = 1; i <= N; i++) begin
      cand = last_idx + WIDTH'(i);
      if (!any && Req[cand]) begin
        winner = cand;
        any    = 1'b1;
      end
    end
  end

  generate
    if (MAXHOLD > 0) begin : g_hold
      logic [CW-1:0] hold_cnt;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          hold_cnt <= '0;
        end else if (state == GRANTED && !Flush && !Done && !hold_expire) begin
          hold_cnt <= hold_cnt + 1'b1;
        end else begin
          hold_cnt <= '0;
        end
      end
      assign hold_expire = (state == GRANTED) && (hold_cnt == CW'(MAXHOLD - 1));
    end else begin : g_nohold
      assign hold_expire = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      GrantValid  <= 1'b0;
      GrantIdx    <= '0;
      HoldTimeout <= 1'b0;
      last_idx    <= WIDTH'(N - 1);
    end else begin
      HoldTimeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any && !Flush) begin
            state      <= GRANTED;
            GrantIdx   <= winner;
            last_idx   <= winner;
            GrantValid <= 1'b1;
          end
        end
        GRANTED: begin
          if (Flush) begin
            state      <= IDLE;
            GrantValid <= 1'b0;
          end else if (Done || hold_expire) begin
            HoldTimeout <= hold_expire && !Done;
            // Zero-bubble handoff: rearbitrate on the current Req in the release cycle.
            if (any) begin
              GrantIdx <= winner;
              last_idx <= winner;
            end else begin
              state      <= IDLE;
              GrantValid <= 1'b0;
            end
          end
        end
        default: begin
          state      <= IDLE;
          GrantValid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rr_grant_index.sv
// tb/tb_rr_grant_index.sv - directed bench for rr_grant_index
// Two instances share stimulus: unlimited hold and MAXHOLD=4.
module tb_rr_grant_index;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Req;
  logic       Done;
  logic       Flush;
  logic       gv, gv_h;
  logic [1:0] gi, gi_h;
  logic       ht, ht_h;
  int         n_cmp  = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  rr_grant_index #(.WIDTH(2), .MAXHOLD(0)) dut (
    .clk(clk), .reset(reset), .Req(Req), .Done(Done), .Flush(Flush),
    .GrantValid(gv), .GrantIdx(gi), .HoldTimeout(ht)
  );

  rr_grant_index #(.WIDTH(2), .MAXHOLD(4)) dut_h (
    .clk(clk), .reset(reset), .Req(Req), .Done(Done), .Flush(Flush),
    .GrantValid(gv_h), .GrantIdx(gi_h), .HoldTimeout(ht_h)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; Req = 4'b0000; Done = 1'b0; Flush = 1'b0;
    #3;
    n_cmp++; if (gv !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", gv); end
    n_cmp++; if (gi !== 2'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", gi); end
    n_cmp++; if (ht !== 1'b0) begin n_fail++; $display("FAIL reset_timeout got %b exp 0", ht); end
    n_cmp++; if (gv_h !== 1'b0 || ht_h !== 1'b0) begin n_fail++; $display("FAIL reset_h got v=%b t=%b exp 0 0", gv_h, ht_h); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_rotation();
    logic [1:0] exp_seq [4];
    exp_seq[0] = 2'd1; exp_seq[1] = 2'd2; exp_seq[2] = 2'd3; exp_seq[3] = 2'd0;
    Req = 4'b1111;
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd0) begin n_fail++; $display("FAIL rot_first got v=%b idx=%0d exp v=1 idx=0", gv, gi); end
    Done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== exp_seq[k]) begin
        n_fail++; $display("FAIL rot_seq%0d got v=%b idx=%0d exp v=1 idx=%0d", k, gv, gi, exp_seq[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    Req = 4'b0100; Done = 1'b1;
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd2) begin n_fail++; $display("FAIL b2b_first got v=%b idx=%0d exp v=1 idx=2", gv, gi); end
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd2) begin n_fail++; $display("FAIL b2b_again got v=%b idx=%0d exp v=1 idx=2", gv, gi); end
  endtask

  task automatic test_hold();
    Req = 4'b0010; Done = 1'b1;
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd1) begin n_fail++; $display("FAIL hold_grant got v=%b idx=%0d exp v=1 idx=1", gv, gi); end
    Req = 4'b0000; Done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if (gv !== 1'b1 || gi !== 2'd1) begin
        n_fail++; $display("FAIL hold_cyc%0d got v=%b idx=%0d exp v=1 idx=1", k, gv, gi);
      end
    end
  endtask

  task automatic test_wrap();
    Req = 4'b1000; Done = 1'b1;
    step();
    n_cmp++; if (gi !== 2'd3) begin n_fail++; $display("FAIL wrap_3 got %0d exp 3", gi); end
    Req = 4'b1001;
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd0) begin n_fail++; $display("FAIL wrap_0 got v=%b idx=%0d exp v=1 idx=0", gv, gi); end
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd3) begin n_fail++; $display("FAIL wrap_back3 got v=%b idx=%0d exp v=1 idx=3", gv, gi); end
    Done = 1'b0;
  endtask

  task automatic test_timeout();
    reset = 1'b1; Req = 4'b0011; Done = 1'b0; Flush = 1'b0;
    step();
    reset = 1'b0;
    step();
    n_cmp++; if (gv_h !== 1'b1 || gi_h !== 2'd0 || ht_h !== 1'b0) begin n_fail++; $display("FAIL to_grant got v=%b idx=%0d t=%b exp 1 0 0", gv_h, gi_h, ht_h); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_cmp++;
      if (gi_h !== 2'd0 || ht_h !== 1'b0) begin
        n_fail++; $display("FAIL to_held%0d got idx=%0d t=%b exp idx=0 t=0", k, gi_h, ht_h);
      end
    end
    step();
    n_cmp++; if (gv_h !== 1'b1 || gi_h !== 2'd1 || ht_h !== 1'b1) begin n_fail++; $display("FAIL to_release got v=%b idx=%0d t=%b exp 1 1 1", gv_h, gi_h, ht_h); end
    n_cmp++; if (gi !== 2'd0 || ht !== 1'b0) begin n_fail++; $display("FAIL to_nolimit got idx=%0d t=%b exp idx=0 t=0", gi, ht); end
    step();
    n_cmp++; if (gi_h !== 2'd1 || ht_h !== 1'b0) begin n_fail++; $display("FAIL to_pulse_end got idx=%0d t=%b exp idx=1 t=0", gi_h, ht_h); end
  endtask

  task automatic test_flush_reset();
    Req = 4'b1111; Done = 1'b1;
    step();
    n_cmp++; if (gi !== 2'd1) begin n_fail++; $display("FAIL fl_pre got %0d exp 1", gi); end
    Flush = 1'b1;
    step();
    n_cmp++; if (gv !== 1'b0 || gi !== 2'd1) begin n_fail++; $display("FAIL fl_drop got v=%b idx=%0d exp v=0 idx=1", gv, gi); end
    step();
    n_cmp++; if (gv !== 1'b0) begin n_fail++; $display("FAIL fl_idle got v=%b exp 0", gv); end
    Flush = 1'b0; Done = 1'b0;
    step();
    n_cmp++; if (gv !== 1'b1 || gi !== 2'd2) begin n_fail++; $display("FAIL fl_regrant got v=%b idx=%0d exp v=1 idx=2", gv, gi); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (gv !== 1'b0 || gi !== 2'd0 || ht !== 1'b0) begin n_fail++; $display("FAIL async_rst got v=%b idx=%0d t=%b exp 0 0 0", gv, gi, ht); end
    n_cmp++; if (gv_h !== 1'b0 || gi_h !== 2'd0 || ht_h !== 1'b0) begin n_fail++; $display("FAIL async_rst_h got v=%b idx=%0d t=%b exp 0 0 0", gv_h, gi_h, ht_h); end
    step();
    reset = 1'b0; Req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_back_to_back();
    test_hold();
    test_wrap();
    test_timeout();
    test_flush_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
